fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS datapath, directly upstream of instrMem.
- Holds the program counter and drives instrMem's address. It also computes next-PC: sequential, branch or jump.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Supports load-use stall, squash on redirect, and an externally requested flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 0.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold PC and IF/ID (hazard unit)
- flush  in  1  insert bubble into IF/ID next edge
- branch_taken  in  1  branch resolved taken in ID
- branch_imm  in  16  raw branch immediate from instruction in ID
- jump  in  1  J-type redirect from ID
- jump_index  in  26  instruction[25:0] of the jump in ID
- imem_addr  out  32  address to instrMem (combinational = pc)
- imem_instr  in  32  instruction returned by instrMem (combinational read)
- ifid_instr  out  32  registered instruction to decode
- ifid_pc4  out  32  registered PC+4 of that instruction
- ifid_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  CNT_W  number of instructions accepted into IF/ID

Behaviour:
- Reset: all state changes only on posedge clk; rst_n=0 has priority over every other input.
  - pc<=RESET_PC&~3
  - ifid_instr<=0 (nop), ifid_pc4<=0, ifid_valid<=0, fetch_count<=0
- imem_addr=pc at all times. The instruction at pc appears on ifid_instr one cycle later (latency 1).
- Next-PC selection on each edge (rst_n=1), priority high to low:
  1. stall=1: pc holds. branch_taken and jump are ignored; ID must keep them asserted until stall drops.
  2. jump=1: pc<={ifid_pc4[31:28], jump_index, 2'b00}
  3. branch_taken=1: pc<=ifid_pc4 + (signext(branch_imm)<<2), 32-bit wrap-around.
  4. Otherwise: pc<=pc+4, wrapping 32'hFFFF_FFFC -> 0.
- IF/ID update on each edge (rst_n=1), priority high to low:
  1. flush=1 or a redirect (jump=1 or branch_taken=1, stall=0): bubble. ifid_instr<=0, ifid_valid<=0, ifid_pc4<=0; fetch_count unchanged.
  2. stall=1: ifid_* hold; fetch_count unchanged.
  3. Otherwise: ifid_instr<=imem_instr, ifid_pc4<=pc+4, ifid_valid<=1, fetch_count<=fetch_count+1 (wraps).
- No branch delay slot: the instruction fetched in the redirect cycle is squashed.
- Redirect bases (ifid_pc4) are valid only when ifid_valid=1. If ifid_valid=0, jump and branch_taken are ignored and treated as sequential.
- stall=1 with flush=1: pc holds and IF/ID becomes a bubble. The instruction at pc is refetched after stall drops.
- jump and branch_taken both 1: jump wins.
- Reset asserted mid-stall or mid-redirect: reset values next edge, with no residue of pending redirect.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0
  - PC_INC = 32'd4
  - typedef ifid_t = struct {instr, pc4, valid}
  - enum npc_sel_t {NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_HOLD}
- Sub-module next_pc: combinational target calculation and selection. It reuses signExtend and shiftLeft2 for the branch offset; jump target is concatenation.
- Registers (pc, IF/ID, counter) live in fetch_stage.

Test Plan:
- Reset + sequential: rst_n=0 two cycles then 1, RESET_PC=0, instrMem words i=32'h1000_0000+i.
  - imem_addr = 0, 4, 8, 12 on successive cycles.
  - ifid_instr = 32'h1000_0000, 32'h1000_0001, ... one cycle behind; ifid_pc4 = 4, 8, ...
  - fetch_count = 1, 2, 3.
- Branch: ifid_pc4=32'h0000_0010, branch_imm=16'hFFFD, branch_taken=1 for one cycle.
  - Next pc = 32'h0000_0004.
  - IF/ID bubble (valid=0, instr=0) that cycle; fetch_count not incremented.
- Jump: ifid_pc4=32'hA000_0040, jump_index=26'h000_0100, jump=1 and branch_taken=1 together.
  - pc = 32'hA000_0400 (jump wins); one bubble.
- Stall: stall=1 for 3 cycles at pc=8, with branch_taken=1 also asserted.
  - pc stays 8; ifid_* unchanged; fetch_count frozen; branch ignored.
  - stall=0: fetch resumes from 8.
- Flush+stall and mid-run reset:
  - stall=1, flush=1: pc holds, ifid_valid=0.
  - Then rst_n=0 during a jump: pc=RESET_PC, all outputs reset values next edge.
- Wrap: pc=32'hFFFF_FFFC sequential -> pc=0; fetch_count at all-ones increments to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch datapath.
//   NOP_INSTR   : encoding loaded into IF/ID for a bubble
//   PC_INC      : sequential PC increment
//   ifid_t      : IF/ID pipeline register contents
//   npc_sel_t   : next-PC source selected each cycle
//   sign_extend : 16-bit to 32-bit sign extension (signExtend)
//   shift_left2 : word-offset to byte-offset shift (shiftLeft2)
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BRANCH,
    NPC_JUMP,
    NPC_HOLD
  } npc_sel_t;

  function automatic logic [31:0] sign_extend(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] shift_left2(input logic [31:0] val);
    return {val[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC calculation and source selection.
// Ports:
//   pc           in  current program counter
//   ifid_pc4     in  PC+4 of the instruction in ID (redirect base)
//   ifid_valid   in  ID holds a real instruction; redirects ignored otherwise
//   stall        in  hold PC
//   jump         in  J-type redirect requested by ID
//   jump_index   in  instruction[25:0] of the jump
//   branch_taken in  branch resolved taken in ID
//   branch_imm   in  raw 16-bit branch immediate
//   seq_pc       out pc + 4 (also the PC+4 captured into IF/ID)
//   npc          out selected next PC
//   sel          out which source was selected
module next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ifid_pc4,
  input  logic        ifid_valid,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  output logic [31:0] seq_pc,
  output logic [31:0] npc,
  output npc_sel_t    sel
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign seq_pc        = pc + PC_INC;
  assign branch_target = ifid_pc4 + shift_left2(sign_extend(branch_imm));
  assign jump_target   = {ifid_pc4[31:28], jump_index, 2'b00};

  always_comb begin
    sel = NPC_SEQ;
    npc = seq_pc;
    // Redirect bases are only meaningful when ID holds a real instruction.
    if (stall) begin
      sel = NPC_HOLD;
      npc = pc;
    end else if (jump && ifid_valid) begin
      sel = NPC_JUMP;
      npc = jump_target;
    end else if (branch_taken && ifid_valid) begin
      sel = NPC_BRANCH;
      npc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection and the
// IF/ID pipeline register.
// Ports:
//   clk, rst_n   in  clock, synchronous active-low reset
//   stall        in  hold PC and IF/ID
//   flush        in  bubble IF/ID next edge
//   branch_taken in  branch redirect from ID, branch_imm its immediate
//   jump         in  jump redirect from ID, jump_index its target field
//   imem_addr    out address to instruction memory (= pc)
//   imem_instr   in  instruction at imem_addr (combinational read)
//   ifid_instr   out registered instruction to decode
//   ifid_pc4     out registered PC+4 of that instruction
//   ifid_valid   out IF/ID holds a real instruction
//   fetch_count  out instructions accepted into IF/ID (wraps)
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [15:0]      branch_imm,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] PcInit = RESET_PC & ~32'd3;
  localparam ifid_t IfidBubble = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  logic [31:0]      pc_q, pc_d, seq_pc;
  ifid_t            ifid_q, ifid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  npc_sel_t         sel;
  logic             redirect;

  next_pc u_next_pc (
    .pc           (pc_q),
    .ifid_pc4     (ifid_q.pc4),
    .ifid_valid   (ifid_q.valid),
    .stall        (stall),
    .jump         (jump),
    .jump_index   (jump_index),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .seq_pc       (seq_pc),
    .npc          (pc_d),
    .sel          (sel)
  );

  // Only an accepted redirect squashes; ignored ones (stall, invalid ID) do not.
  assign redirect = (sel == NPC_JUMP) || (sel == NPC_BRANCH);

  always_comb begin
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    if (flush || redirect) begin
      ifid_d = IfidBubble;
    end else if (!stall) begin
      ifid_d = '{instr: imem_instr, pc4: seq_pc, valid: 1'b1};
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= PcInit;
      ifid_q <= IfidBubble;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_pc4    = ifid_q.pc4;
  assign ifid_valid  = ifid_q.valid;
  assign fetch_count = cnt_q;

endmodule
